// File: rtl/adder_acc.sv
`default_nettype none
// ============================================================================
//  Module   : adder_acc
//  Purpose  : Registered unsigned adder / subtractor / accumulator with a
//             valid/ready handshake on both sides, carry/borrow reporting
//             and a sticky overflow flag.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   1      rising-edge clock
//    rst_n         in   1      asynchronous active-low reset
//    i_in_valid    in   1      operand beat valid
//    o_in_ready    out  1      beat can be accepted (!o_out_valid || i_out_ready)
//    i_mode        in   2      00 ADD, 01 SUB, 10 ACC, 11 LOAD
//    i_a           in   WIDTH  operand A
//    i_b           in   WIDTH  operand B (ignored in ACC and LOAD)
//    i_clear       in   1      synchronous clear of accumulator and sticky flag
//    o_out_valid   out  1      result valid
//    i_out_ready   in   1      consumer accepts the result
//    o_sum         out  WIDTH  registered result
//    o_overflow    out  1      carry/borrow of the current result
//    o_ovf_sticky  out  1      OR of o_overflow since reset or last clear
// ----------------------------------------------------------------------------
//  Build option
//    ADDER_SAT_EN  when defined, results saturate instead of wrapping
//                  (all ones on carry, zero on borrow); overflow still reported
// ============================================================================
module adder_acc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_clear,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_overflow,
  output logic             o_ovf_sticky
);

  localparam logic [1:0] c_MODE_ADD  = 2'b00;
  localparam logic [1:0] c_MODE_SUB  = 2'b01;
  localparam logic [1:0] c_MODE_ACC  = 2'b10;
  localparam logic [1:0] c_MODE_LOAD = 2'b11;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_overflow;
  logic             r_ovf_sticky;
  logic [WIDTH-1:0] r_acc;

  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_acc_base;
  logic [WIDTH:0]   w_wide;
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_sticky_next;

  // Single-entry output buffer: a new beat may enter whenever the held
  // result is empty or leaves on this same edge.
  assign w_in_ready = !r_out_valid || i_out_ready;
  assign w_accept   = i_in_valid && w_in_ready;

  // Clear takes effect before a same-cycle beat, so ACC sees a zero base.
  assign w_acc_base = i_clear ? '0 : r_acc;

  always_comb begin
    w_wide = '0;
    w_raw  = '0;
    w_ovf  = 1'b0;
    case (i_mode)
      c_MODE_ADD: begin
        w_wide = {1'b0, i_a} + {1'b0, i_b};
        w_raw  = w_wide[WIDTH-1:0];
        w_ovf  = w_wide[WIDTH];
      end
      c_MODE_SUB: begin
        // The extra MSB of a WIDTH+1 subtraction is the unsigned borrow.
        w_wide = {1'b0, i_a} - {1'b0, i_b};
        w_raw  = w_wide[WIDTH-1:0];
        w_ovf  = w_wide[WIDTH];
      end
      c_MODE_ACC: begin
        w_wide = {1'b0, w_acc_base} + {1'b0, i_a};
        w_raw  = w_wide[WIDTH-1:0];
        w_ovf  = w_wide[WIDTH];
      end
      default: begin // c_MODE_LOAD
        w_raw = i_a;
        w_ovf = 1'b0;
      end
    endcase
  end

`ifdef ADDER_SAT_EN
  // Borrow clamps to zero, carry clamps to all ones.
  always_comb begin
    w_res = w_raw;
    if (w_ovf) begin
      w_res = (i_mode == c_MODE_SUB) ? '0 : '1;
    end
  end
`else
  assign w_res = w_raw;
`endif

  always_comb begin
    w_acc_next = w_acc_base;
    if (w_accept) begin
      if (i_mode == c_MODE_ACC) begin
        w_acc_next = w_res;
      end else if (i_mode == c_MODE_LOAD) begin
        w_acc_next = i_a;
      end
    end
  end

  assign w_sticky_next = (i_clear ? 1'b0 : r_ovf_sticky) | (w_accept & w_ovf);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_sum        <= '0;
      r_overflow   <= 1'b0;
      r_ovf_sticky <= 1'b0;
      r_acc        <= '0;
    end else begin
      r_acc        <= w_acc_next;
      r_ovf_sticky <= w_sticky_next;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_sum       <= w_res;
        r_overflow  <= w_ovf;
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_in_ready   = w_in_ready;
  assign o_out_valid  = r_out_valid;
  assign o_sum        = r_sum;
  assign o_overflow   = r_overflow;
  assign o_ovf_sticky = r_ovf_sticky;

endmodule
`default_nettype wire

// File: tb/tb_adder_acc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_acc
//  Purpose  : Self-checking bench for adder_acc (WIDTH = 8). Expected results
//             are queued when a beat is accepted and compared while the DUT
//             presents them. Honours ADDER_SAT_EN for expected values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adder_acc;

  localparam int W = 8;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, LOAD = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_in_valid = 1'b0;
  logic         o_in_ready;
  logic [1:0]   i_mode = 2'b00;
  logic [W-1:0] i_a = '0;
  logic [W-1:0] i_b = '0;
  logic         i_clear = 1'b0;
  logic         o_out_valid;
  logic         i_out_ready = 1'b1;
  logic [W-1:0] o_sum;
  logic         o_overflow;
  logic         o_ovf_sticky;

  always #5 clk = ~clk;

  adder_acc #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .i_mode       (i_mode),
    .i_a          (i_a),
    .i_b          (i_b),
    .i_clear      (i_clear),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_sum        (o_sum),
    .o_overflow   (o_overflow),
    .o_ovf_sticky (o_ovf_sticky)
  );

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard of {overflow, sum}, plus the bench's own view of DUT state.
  logic [W:0]   sb[$];
  logic [W-1:0] m_acc = '0;
  logic         m_sticky = 1'b0;
  logic         m_ov = 1'b0;

`ifdef ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // Reference result using integer arithmetic: returns {overflow, sum}.
  function automatic logic [W:0] ref_res(input logic [1:0] md, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [W-1:0] acc);
    int unsigned r;
    int unsigned lim = 1 << W;
    logic ov;
    logic [W-1:0] s;
    case (md)
      ADD: begin
        r = int'(a) + int'(b);
        ov = (r >= lim);
        s = (ov && SAT) ? {W{1'b1}} : W'(r % lim);
      end
      SUB: begin
        ov = (a < b);
        r = ov ? (lim + int'(a) - int'(b)) : (int'(a) - int'(b));
        s = (ov && SAT) ? '0 : W'(r);
      end
      ACC: begin
        r = int'(acc) + int'(a);
        ov = (r >= lim);
        s = (ov && SAT) ? {W{1'b1}} : W'(r % lim);
      end
      default: begin
        ov = 1'b0;
        s = a;
      end
    endcase
    return {ov, s};
  endfunction

  // One clock cycle: drive inputs, check pre-edge outputs at the falling
  // edge, update the model, then check post-edge state 1 time unit later.
  // use_exp selects a fixed expected result instead of the reference model.
  task automatic cycle(input logic v, input logic [1:0] md, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic clr, input logic ordy,
                       input logic use_exp, input logic [W-1:0] es, input logic eo);
    logic exp_rdy, acc_ok;
    logic [W-1:0] base;
    logic [W:0] r;
    i_in_valid = v; i_mode = md; i_a = a; i_b = b; i_clear = clr; i_out_ready = ordy;
    @(negedge clk);
    exp_rdy = !m_ov || ordy;
    n_vec++;
    if (o_in_ready !== exp_rdy) begin
      n_err++;
      $display("FAIL in_ready: got %b expected %b at %0t", o_in_ready, exp_rdy, $time);
    end
    if (m_ov) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_empty: result pending but none expected at %0t", $time);
      end else if (o_out_valid !== 1'b1 || o_sum !== sb[0][W-1:0] || o_overflow !== sb[0][W]) begin
        n_err++;
        $display("FAIL result: got valid=%b sum=%h ovf=%b expected valid=1 sum=%h ovf=%b at %0t",
                 o_out_valid, o_sum, o_overflow, sb[0][W-1:0], sb[0][W], $time);
      end
      if (ordy && sb.size() != 0) void'(sb.pop_front());
    end
    acc_ok = v && exp_rdy;
    base = clr ? '0 : m_acc;
    if (clr) m_sticky = 1'b0;
    if (acc_ok) begin
      r = ref_res(md, a, b, base);
      if (md == ACC) base = r[W-1:0];
      if (md == LOAD) base = a;
      m_sticky = m_sticky | r[W];
      sb.push_back(use_exp ? {eo, es} : r);
    end
    m_acc = base;
    m_ov = acc_ok ? 1'b1 : (ordy ? 1'b0 : m_ov);
    @(posedge clk);
    #1;
    n_vec++;
    if (o_out_valid !== m_ov || o_ovf_sticky !== m_sticky) begin
      n_err++;
      $display("FAIL post_edge: got valid=%b sticky=%b expected valid=%b sticky=%b at %0t",
               o_out_valid, o_ovf_sticky, m_ov, m_sticky, $time);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, ADD, '0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic beat(input logic [1:0] md, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] es, input logic eo);
    cycle(1'b1, md, a, b, 1'b0, 1'b1, 1'b1, es, eo);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_vec++;
    if (o_out_valid !== 1'b0 || o_sum !== 8'h00 || o_overflow !== 1'b0 ||
        o_ovf_sticky !== 1'b0 || o_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: got v=%b s=%h o=%b st=%b rdy=%b expected 0 00 0 0 1",
               o_out_valid, o_sum, o_overflow, o_ovf_sticky, o_in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    sb.delete(); m_acc = '0; m_sticky = 1'b0; m_ov = 1'b0;
    idle(1);
  endtask

  task automatic test_add();
    beat(ADD, 8'h7F, 8'h01, 8'h80, 1'b0);
    beat(ADD, 8'hFF, 8'h02, SAT ? 8'hFF : 8'h01, 1'b1);
    idle(1);
    n_vec++;
    if (o_ovf_sticky !== 1'b1) begin
      n_err++;
      $display("FAIL add_sticky: got %b expected 1", o_ovf_sticky);
    end
  endtask

  task automatic test_sub();
    beat(SUB, 8'h03, 8'h05, SAT ? 8'h00 : 8'hFE, 1'b1);
    beat(SUB, 8'h09, 8'h04, 8'h05, 1'b0);
    idle(1);
  endtask

  task automatic test_acc_chain();
    beat(LOAD, 8'h10, 8'h55, 8'h10, 1'b0);
    beat(ACC, 8'h20, 8'hAA, 8'h30, 1'b0);
    beat(ACC, 8'hE0, 8'h00, SAT ? 8'hFF : 8'h10, 1'b1);
    idle(1);
  endtask

  task automatic test_backpressure();
    beat(ADD, 8'h11, 8'h22, 8'h33, 1'b0);
    // Result pending, consumer stalls while a new beat is offered.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, SUB, 8'h40, 8'h01, 1'b0, 1'b0, 1'b1, 8'h3F, 1'b0);
    cycle(1'b1, SUB, 8'h40, 8'h01, 1'b0, 1'b1, 1'b1, 8'h3F, 1'b0);
    idle(1);
  endtask

  task automatic test_clear();
    beat(ADD, 8'hFF, 8'h02, SAT ? 8'hFF : 8'h01, 1'b1);
    beat(LOAD, 8'h40, 8'h00, 8'h40, 1'b0);
    cycle(1'b1, ACC, 8'h05, 8'h00, 1'b1, 1'b1, 1'b1, 8'h05, 1'b0);
    n_vec++;
    if (o_ovf_sticky !== 1'b0 || o_sum !== 8'h05) begin
      n_err++;
      $display("FAIL clear_with_acc: got sum=%h sticky=%b expected 05 0", o_sum, o_ovf_sticky);
    end
    idle(1);
  endtask

  task automatic test_async_reset();
    beat(LOAD, 8'h77, 8'h00, 8'h77, 1'b0);
    beat(ACC, 8'h01, 8'h00, 8'h78, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (o_out_valid !== 1'b0 || o_sum !== 8'h00 || o_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset: got valid=%b sum=%h rdy=%b expected 0 00 1",
               o_out_valid, o_sum, o_in_ready);
    end
    sb.delete(); m_acc = '0; m_sticky = 1'b0; m_ov = 1'b0;
    i_in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    // Accumulator must be back at zero.
    beat(ACC, 8'h03, 8'h00, 8'h03, 1'b0);
    idle(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
            8'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0),
            1'b0, '0, 1'b0);
    idle(2);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_acc_chain();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_random();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results never produced, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
